instruction_prefetch_unit: RTL and testbench

INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

---
 rtl/instruction_prefetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_prefetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: a fetch PC plus a small queue of {instruction, PC+4} pairs,
// fed by a fixed one-cycle-latency instruction memory and redirected by branches and jumps.
module instruction_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    output logic [ADDR_W-1:0]          ImemAddr,
    output logic                       ImemRe,
    input  logic [INSTR_W-1:0]         ImemData,
    output logic [INSTR_W-1:0]         Instruction,
    output logic [ADDR_W-1:0]          NextInstruct,
    output logic                       InstrValid,
    input  logic                       InstrReady,
    input  logic                       Branch,
    input  logic [ADDR_W-1:0]          BranchBase,
    input  logic [ADDR_W-1:0]          BranchOffset,
    input  logic                       Jump,
    input  logic [25:0]                JumpIndex,
    output logic [$clog2(QDEPTH):0]    QueueCount
);

    localparam int PW = $clog2(QDEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc4_q, inflight_pc4_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]        count_q, count_d;

    logic [INSTR_W-1:0] fifo_instr_q [QDEPTH];
    logic [ADDR_W-1:0]  fifo_pc4_q   [QDEPTH];

    logic               redirect;
    logic               pop;
    logic               push;
    logic [PW+1:0]      occupancy;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  redirect_target;

    // With a 28-bit address space the jump target has no inherited upper bits.
    generate
        if (ADDR_W > 28) begin : g_jump_hi
            assign jump_target = {BranchBase[ADDR_W-1:28], JumpIndex, 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {JumpIndex, 2'b00};
        end
    endgenerate

    always_comb begin
        redirect        = Jump | Branch;
        redirect_target = Jump ? jump_target : BranchBase + (BranchOffset << 2);

        InstrValid   = Reset & (count_q != '0);
        Instruction  = InstrValid ? fifo_instr_q[rd_ptr_q] : '0;
        NextInstruct = InstrValid ? fifo_pc4_q[rd_ptr_q]   : '0;
        QueueCount   = count_q;
        pop          = InstrValid & InstrReady;

        // Reserve a slot for the outstanding return so the queue can never overflow.
        occupancy = (PW+2)'(count_q) + (PW+2)'(inflight_q) - (PW+2)'(pop);
        ImemRe    = Reset & ~redirect & (occupancy < (PW+2)'(QDEPTH));
        ImemAddr  = pc_q;

        push = Reset & inflight_q & ~redirect;

        pc_d           = pc_q;
        inflight_d     = ImemRe;
        inflight_pc4_d = inflight_pc4_q;
        rd_ptr_d       = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d       = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d        = count_q + (PW+1)'(push) - (PW+1)'(pop);

        if (ImemRe) begin
            pc_d           = pc_q + ADDR_W'(4);
            inflight_pc4_d = pc_q + ADDR_W'(4);
        end

        // A redirect flushes the queue and drops the return landing this cycle.
        if (redirect) begin
            pc_d       = redirect_target;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q           <= RESET_PC;
            inflight_q     <= 1'b0;
            inflight_pc4_q <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_pc4_q <= inflight_pc4_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= ImemData;
            fifo_pc4_q[wr_ptr_q]   <= inflight_pc4_q;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Self-checking bench for instruction_prefetch_unit: directed vector table, corner-case
// sequences and a randomized run compared against a queue-based reference model.
module tb_instruction_prefetch_unit;

    localparam int QD = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] next_instr;
    logic        instr_valid;
    logic        ready;
    logic        br;
    logic [31:0] br_base;
    logic [31:0] br_off;
    logic        jmp;
    logic [25:0] jidx;
    logic [2:0]  queue_count;

    instruction_prefetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .QDEPTH(QD), .RESET_PC(RST_PC)
    ) dut (
        .Clk(clk), .Reset(rst_n),
        .ImemAddr(imem_addr), .ImemRe(imem_re), .ImemData(imem_data),
        .Instruction(instr), .NextInstruct(next_instr), .InstrValid(instr_valid),
        .InstrReady(ready), .Branch(br), .BranchBase(br_base), .BranchOffset(br_off),
        .Jump(jmp), .JumpIndex(jidx), .QueueCount(queue_count)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          ready;
        bit          br;
        bit          jmp;
        logic [31:0] base;
        logic [31:0] off;
        logic [25:0] jidx;
        bit          e_re;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ni;
        int          e_cnt;
    } vec_t;

    vec_t vecs[17];
    vec_t vnone;

    // Reference model: fetch queue as SV queues, fetch PC and one outstanding request.
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc4[$];
    logic [31:0] m_pc;
    bit          m_inf;
    logic [31:0] m_inf_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    function automatic vec_t mk(input bit r, input bit b, input bit j,
                                input logic [31:0] base, input logic [31:0] off,
                                input logic [25:0] ji, input bit e_re,
                                input logic [31:0] e_addr, input bit e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_ni,
                                input int e_cnt);
        vec_t v;
        v.ready = r; v.br = b; v.jmp = j; v.base = base; v.off = off; v.jidx = ji;
        v.e_re = e_re; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_ni = e_ni; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle(input bit do_check, input bit use_vec, input vec_t ve);
        bit          redirect, pop, e_valid, e_re, req;
        int          occ;
        logic [31:0] req_addr;
        #1;
        redirect = rst_n && (br || jmp);
        e_valid  = rst_n && (mq_instr.size() > 0);
        pop      = e_valid && ready;
        occ      = mq_instr.size() + int'(m_inf) - int'(pop);
        e_re     = rst_n && !(br || jmp) && (occ < QD);
        if (do_check) begin
            chk("model_QueueCount", 64'(queue_count), 64'(mq_instr.size()));
            chk("model_InstrValid", 64'(instr_valid), 64'(e_valid));
            chk("model_ImemRe", 64'(imem_re), 64'(e_re));
            if (e_re) chk("model_ImemAddr", 64'(imem_addr), 64'(m_pc));
            chk("model_Instruction", 64'(instr), e_valid ? 64'(mq_instr[0]) : 64'h0);
            chk("model_NextInstruct", 64'(next_instr), e_valid ? 64'(mq_pc4[0]) : 64'h0);
        end
        if (use_vec) begin
            chk("vec_QueueCount", 64'(queue_count), 64'(ve.e_cnt));
            chk("vec_ImemRe", 64'(imem_re), 64'(ve.e_re));
            if (ve.e_re) chk("vec_ImemAddr", 64'(imem_addr), 64'(ve.e_addr));
            chk("vec_InstrValid", 64'(instr_valid), 64'(ve.e_valid));
            if (ve.e_valid) begin
                chk("vec_Instruction", 64'(instr), 64'(ve.e_instr));
                chk("vec_NextInstruct", 64'(next_instr), 64'(ve.e_ni));
            end
        end
        req      = imem_re;
        req_addr = imem_addr;
        if (!rst_n) begin
            mq_instr.delete(); mq_pc4.delete();
            m_pc = RST_PC; m_inf = 0;
        end else begin
            if (pop) begin
                void'(mq_instr.pop_front());
                void'(mq_pc4.pop_front());
            end
            if (redirect) begin
                mq_instr.delete(); mq_pc4.delete();
                m_pc  = jmp ? {br_base[31:28], jidx, 2'b00} : br_base + (br_off << 2);
                m_inf = 0;
            end else begin
                if (m_inf) begin
                    mq_instr.push_back(mem_word(m_inf_addr));
                    mq_pc4.push_back(m_inf_addr + 32'd4);
                end
                if (e_re) begin
                    m_inf = 1; m_inf_addr = m_pc; m_pc = m_pc + 32'd4;
                end else begin
                    m_inf = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        imem_data = req ? mem_word(req_addr) : $urandom;
        @(negedge clk);
    endtask

    task automatic set_in(input bit r, input bit b, input bit j,
                          input logic [31:0] base, input logic [31:0] off, input logic [25:0] ji);
        ready = r; br = b; jmp = j; br_base = base; br_off = off; jidx = ji;
    endtask

    initial begin
        bit found;
        vnone = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; imem_data = '0;
        set_in(1, 0, 0, 0, 0, 0);
        m_pc = RST_PC; m_inf = 0; m_inf_addr = '0;

        vecs[0]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h0, 0, 32'h0, 32'h0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4, 0, 32'h0, 32'h0, 0);
        vecs[2]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h8, 1, 32'h1000_0000, 32'h4, 1);
        vecs[3]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'hC, 1, 32'h1000_0001, 32'h8, 1);
        vecs[4]  = mk(1, 1, 0, 32'h20, 32'hFFFF_FFFE, 26'h0, 0, 32'h0, 1, 32'h1000_0002, 32'hC, 1);
        vecs[5]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h18, 0, 32'h0, 32'h0, 0);
        vecs[6]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h1C, 0, 32'h0, 32'h0, 0);
        vecs[7]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h20, 1, 32'h1000_0006, 32'h1C, 1);
        vecs[8]  = mk(1, 1, 1, 32'h4000_0010, 32'h0, 26'h40, 0, 32'h0, 1, 32'h1000_0007, 32'h20, 1);
        vecs[9]  = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_0100, 0, 32'h0, 32'h0, 0);
        vecs[10] = mk(0, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_0104, 0, 32'h0, 32'h0, 0);
        vecs[11] = mk(0, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_0108, 1, 32'h2000_0040, 32'h4000_0104, 1);
        vecs[12] = mk(0, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_010C, 1, 32'h2000_0040, 32'h4000_0104, 2);
        vecs[13] = mk(0, 0, 0, 32'h0, 32'h0, 26'h0, 0, 32'h0, 1, 32'h2000_0040, 32'h4000_0104, 3);
        vecs[14] = mk(0, 0, 0, 32'h0, 32'h0, 26'h0, 0, 32'h0, 1, 32'h2000_0040, 32'h4000_0104, 4);
        vecs[15] = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_0110, 1, 32'h2000_0040, 32'h4000_0104, 4);
        vecs[16] = mk(1, 0, 0, 32'h0, 32'h0, 26'h0, 1, 32'h4000_0114, 1, 32'h2000_0041, 32'h4000_0108, 3);

        // Reset: the first edge clears state, the second cycle checks the reset values.
        cycle(0, 0, vnone);
        #1;
        chk("reset_QueueCount", 64'(queue_count), 64'h0);
        chk("reset_InstrValid", 64'(instr_valid), 64'h0);
        chk("reset_ImemRe", 64'(imem_re), 64'h0);
        chk("reset_Instruction", 64'(instr), 64'h0);
        chk("reset_NextInstruct", 64'(next_instr), 64'h0);
        cycle(1, 0, vnone);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            set_in(vecs[i].ready, vecs[i].br, vecs[i].jmp, vecs[i].base, vecs[i].off, vecs[i].jidx);
            cycle(1, 1, vecs[i]);
            $display("vec %0d: ready=%0b br=%0b jmp=%0b addr=%08h re=%0b valid=%0b instr=%08h cnt=%0d",
                     i, vecs[i].ready, vecs[i].br, vecs[i].jmp, imem_addr, imem_re,
                     instr_valid, instr, queue_count);
        end

        // Address wrap at the top of the address space.
        set_in(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 26'h0);
        cycle(1, 0, vnone);
        set_in(1, 0, 0, 32'h0, 32'h0, 26'h0);
        #1; chk("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
        cycle(1, 0, vnone);
        #1; chk("wrap_addr1", 64'(imem_addr), 64'h0);
        cycle(1, 0, vnone);
        #1; chk("wrap_ni", 64'(next_instr), 64'h0);
        chk("wrap_instr", 64'(instr), 64'h4FFF_FFFF);
        cycle(1, 0, vnone);
        $display("seq wrap: done at t=%0t", $time);

        // Back-to-back redirects: the later one wins and nothing stale is queued.
        set_in(1, 1, 0, 32'h100, 32'h4, 26'h0);
        cycle(1, 0, vnone);
        set_in(1, 0, 1, 32'h0, 32'h0, 26'h123);
        cycle(1, 0, vnone);
        set_in(1, 0, 0, 32'h0, 32'h0, 26'h0);
        #1; chk("redir2_addr", 64'(imem_addr), 64'h48C);
        chk("redir2_valid", 64'(instr_valid), 64'h0);
        cycle(1, 0, vnone);
        cycle(1, 0, vnone);
        #1; chk("redir2_instr", 64'(instr), 64'(mem_word(32'h48C)));
        cycle(1, 0, vnone);
        $display("seq double redirect: done at t=%0t", $time);

        // Reset mid-stream with three entries queued and a request outstanding.
        set_in(0, 0, 0, 32'h0, 32'h0, 26'h0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mq_instr.size() == 3 && m_inf) found = 1;
            else cycle(1, 0, vnone);
        end
        chk("midreset_reach", 64'(found), 64'h1);
        #1; chk("midreset_pre_cnt", 64'(queue_count), 64'h3);
        rst_n = 1'b0;
        cycle(1, 0, vnone);
        rst_n = 1'b1;
        set_in(1, 0, 0, 32'h0, 32'h0, 26'h0);
        #1;
        chk("midreset_cnt", 64'(queue_count), 64'h0);
        chk("midreset_valid", 64'(instr_valid), 64'h0);
        chk("midreset_re", 64'(imem_re), 64'h1);
        chk("midreset_addr", 64'(imem_addr), 64'(RST_PC));
        cycle(1, 0, vnone);
        $display("seq mid reset: done at t=%0t", $time);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 31);
            rst_n   = ($urandom_range(0, 199) != 0);
            ready   = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            br      = (r == 0) || (r == 2);
            jmp     = (r == 1) || (r == 2);
            br_base = $urandom & 32'hFFFF_FFFC;
            br_off  = (r == 3) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
            jidx    = 26'($urandom);
            cycle(1, 0, vnone);
        end
        $display("random: %0d cycles done", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
